l1_cache_ctrl: RTL and testbench

//  Set-associative, write-back, write-allocate L1 data cache between the CPU and an L2/memory port.

---
 rtl/l1_cache_pkg.sv | 31 +++
 rtl/l1_cache_ctrl_if.sv | 42 ++++
 rtl/l1_lru_set.sv | 51 +++++
 rtl/l1_cache_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_l1_cache_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/l1_cache_pkg.sv
// +------------------------------------------------------------------------+
// | l1_cache_pkg : shared types and default geometry for the L1 data cache  |
// | Revision 1.0                                                            |
// +------------------------------------------------------------------------+
`default_nettype none

package l1_cache_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_CACHE_SIZE = 1024;
  localparam int DEF_BLOCK_SIZE = 16;
  localparam int DEF_NUM_WAYS   = 4;

  localparam int WORDS    = DEF_BLOCK_SIZE / (DEF_DATA_WIDTH / 8);
  localparam int SETS     = DEF_CACHE_SIZE / (DEF_BLOCK_SIZE * DEF_NUM_WAYS);
  localparam int OFFSET_W = $clog2(DEF_BLOCK_SIZE);
  localparam int INDEX_W  = $clog2(SETS);
  localparam int TAG_W    = DEF_ADDR_WIDTH - INDEX_W - OFFSET_W;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_REFILL    = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/l1_cache_ctrl_if.sv
// +------------------------------------------------------------------------+
// | l1_cache_ctrl_if : CPU-side and L2-side buses of the L1 cache           |
// | slave = cache view, master = load/store unit plus L2 view               |
// | Revision 1.0                                                            |
// +------------------------------------------------------------------------+
`default_nettype none

interface l1_cache_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_data_in;
  logic [DATA_WIDTH-1:0] cpu_data_out;
  logic                  cpu_read;
  logic                  cpu_write;
  logic                  cpu_ready;
  logic                  cpu_hit;
  logic [ADDR_WIDTH-1:0] l2_cache_addr;
  logic [DATA_WIDTH-1:0] l2_cache_data_out;
  logic [DATA_WIDTH-1:0] l2_cache_data_in;
  logic                  l2_cache_read;
  logic                  l2_cache_write;
  logic                  l2_cache_ready;
  logic                  l2_cache_hit;

  modport slave (
    input  cpu_addr, cpu_data_in, cpu_read, cpu_write,
    input  l2_cache_data_in, l2_cache_ready, l2_cache_hit,
    output cpu_data_out, cpu_ready, cpu_hit,
    output l2_cache_addr, l2_cache_data_out, l2_cache_read, l2_cache_write
  );

  modport master (
    output cpu_addr, cpu_data_in, cpu_read, cpu_write,
    output l2_cache_data_in, l2_cache_ready, l2_cache_hit,
    input  cpu_data_out, cpu_ready, cpu_hit,
    input  l2_cache_addr, l2_cache_data_out, l2_cache_read, l2_cache_write
  );
endinterface

`default_nettype wire

// File: rtl/l1_lru_set.sv
// +------------------------------------------------------------------------+
// | l1_lru_set : true-LRU age counters for one cache set                    |
// | Revision 1.0                                                            |
// +------------------------------------------------------------------------+
`default_nettype none

module l1_lru_set #(
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             access_valid,
  input  logic [WAY_W-1:0] access_way,
  output logic [WAY_W-1:0] lru_way
);

  localparam logic [WAY_W-1:0] AGE_MAX = {WAY_W{1'b1}};

  logic [WAY_W-1:0] r_age [NUM_WAYS];
  logic [WAY_W-1:0] w_max_age;

  // Ways no older than the accessed one age by one; starting from all-zero
  // this converges to a strict age permutation as the set fills.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < NUM_WAYS; w++) r_age[w] <= '0;
    end else if (access_valid) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WAY_W'(w) == access_way)
          r_age[w] <= '0;
        else if (r_age[w] <= r_age[access_way] && r_age[w] != AGE_MAX)
          r_age[w] <= r_age[w] + 1'b1;
      end
    end
  end

  always_comb begin
    lru_way   = '0;
    w_max_age = r_age[0];
    for (int w = 1; w < NUM_WAYS; w++) begin
      if (r_age[w] > w_max_age) begin
        w_max_age = r_age[w];
        lru_way   = WAY_W'(w);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/l1_cache_ctrl.sv
// +------------------------------------------------------------------------+
// | l1_cache_ctrl : set-associative write-back write-allocate L1 D-cache    |
// | Optional macro L1_PERF_CNT_EN adds hit_count/miss_count outputs.        |
// | Revision 1.0                                                            |
// +------------------------------------------------------------------------+
`default_nettype none

module l1_cache_ctrl
  import l1_cache_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CACHE_SIZE = DEF_CACHE_SIZE,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int NUM_WAYS   = DEF_NUM_WAYS
) (
  input  logic              clk,
  input  logic              rst,
  l1_cache_ctrl_if.slave    bus
`ifdef L1_PERF_CNT_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int N_WORDS  = BLOCK_SIZE / (DATA_WIDTH / 8);
  localparam int N_SETS   = CACHE_SIZE / (BLOCK_SIZE * NUM_WAYS);
  localparam int BYTE_W   = $clog2(DATA_WIDTH / 8);
  localparam int OFF_W    = $clog2(BLOCK_SIZE);
  localparam int WSEL_W   = OFF_W - BYTE_W;
  localparam int IDX_W    = $clog2(N_SETS);
  localparam int TAG_BITS = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int WAY_W    = $clog2(NUM_WAYS);
  localparam logic [WSEL_W-1:0] LAST_WORD = WSEL_W'(N_WORDS - 1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_op_write;
  logic [WSEL_W-1:0]     r_word;
  logic [WAY_W-1:0]      r_vway;
  logic [TAG_BITS-1:0]   r_vtag;

  logic [NUM_WAYS-1:0]   r_valid [N_SETS];
  logic [NUM_WAYS-1:0]   r_dirty [N_SETS];
  logic [TAG_BITS-1:0]   r_tag   [N_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0] r_data  [N_SETS][NUM_WAYS][N_WORDS];

  logic                  r_cpu_ready;
  logic                  r_cpu_hit;
  logic [DATA_WIDTH-1:0] r_cpu_data_out;
  logic [ADDR_WIDTH-1:0] r_l2_addr;
  logic [DATA_WIDTH-1:0] r_l2_wdata;
  logic                  r_l2_read;
  logic                  r_l2_write;

  logic [IDX_W-1:0]      w_idx;
  logic [TAG_BITS-1:0]   w_tag;
  logic [WSEL_W-1:0]     w_woff;
  logic                  w_hit;
  logic [WAY_W-1:0]      w_hit_way;
  logic                  w_has_inv;
  logic [WAY_W-1:0]      w_inv_way;
  logic [WAY_W-1:0]      w_victim;
  logic [WAY_W-1:0]      w_set_lru [N_SETS];
  logic                  w_hit_wr;
  logic                  w_fill_we;
  logic                  w_fill_last;
  logic                  w_lru_acc;
  logic [WAY_W-1:0]      w_lru_way_in;
  logic                  w_unused;

  assign w_idx  = r_addr[OFF_W +: IDX_W];
  assign w_tag  = r_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign w_woff = r_addr[BYTE_W +: WSEL_W];

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!w_hit && r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!w_has_inv && !r_valid[w_idx][w]) begin
        w_has_inv = 1'b1;
        w_inv_way = WAY_W'(w);
      end
    end
  end

  assign w_victim     = w_has_inv ? w_inv_way : w_set_lru[w_idx];
  assign w_hit_wr     = (r_state == ST_LOOKUP) && w_hit && r_op_write;
  assign w_fill_we    = (r_state == ST_REFILL) && r_l2_read && bus.l2_cache_ready;
  assign w_fill_last  = w_fill_we && (r_word == LAST_WORD);
  assign w_lru_acc    = ((r_state == ST_LOOKUP) && w_hit) || w_fill_last;
  assign w_lru_way_in = (r_state == ST_LOOKUP) ? w_hit_way : r_vway;

  generate
    for (genvar s = 0; s < N_SETS; s++) begin : g_lru
      l1_lru_set #(
        .NUM_WAYS (NUM_WAYS),
        .WAY_W    (WAY_W)
      ) u_lru (
        .clk          (clk),
        .rst          (rst),
        .access_valid (w_lru_acc && (w_idx == IDX_W'(s))),
        .access_way   (w_lru_way_in),
        .lru_way      (w_set_lru[s])
      );
    end
  endgenerate

  // Data storage carries no reset; the pending store is merged after the
  // last refill word so it wins when both target the same word.
  always_ff @(posedge clk) begin
    if (w_fill_we)
      r_data[w_idx][r_vway][r_word] <= bus.l2_cache_data_in;
    if (w_hit_wr)
      r_data[w_idx][w_hit_way][w_woff] <= r_wdata;
    if (w_fill_last && r_op_write)
      r_data[w_idx][r_vway][w_woff] <= r_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_op_write     <= 1'b0;
      r_word         <= '0;
      r_vway         <= '0;
      r_vtag         <= '0;
      r_cpu_ready    <= 1'b0;
      r_cpu_hit      <= 1'b0;
      r_cpu_data_out <= '0;
      r_l2_addr      <= '0;
      r_l2_wdata     <= '0;
      r_l2_read      <= 1'b0;
      r_l2_write     <= 1'b0;
      for (int s = 0; s < N_SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) r_tag[s][w] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cpu_read || bus.cpu_write) begin
            r_addr     <= bus.cpu_addr;
            r_wdata    <= bus.cpu_data_in;
            r_op_write <= bus.cpu_write;
            r_state    <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (w_hit) begin
            if (r_op_write)
              r_dirty[w_idx][w_hit_way] <= 1'b1;
            else
              r_cpu_data_out <= r_data[w_idx][w_hit_way][w_woff];
            r_cpu_ready <= 1'b1;
            r_cpu_hit   <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_vway <= w_victim;
            r_vtag <= r_tag[w_idx][w_victim];
            r_word <= '0;
            if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) begin
              r_state <= ST_WRITEBACK;
            end else begin
              r_valid[w_idx][w_victim] <= 1'b0;
              r_state                  <= ST_REFILL;
            end
          end
        end
        ST_WRITEBACK: begin
          if (!r_l2_write) begin
            r_l2_write <= 1'b1;
            r_l2_addr  <= {r_vtag, w_idx, r_word, {BYTE_W{1'b0}}};
            r_l2_wdata <= r_data[w_idx][r_vway][r_word];
          end else if (bus.l2_cache_ready) begin
            r_l2_write <= 1'b0;
            r_word     <= r_word + 1'b1;
            if (r_word == LAST_WORD) begin
              r_valid[w_idx][r_vway] <= 1'b0;
              r_dirty[w_idx][r_vway] <= 1'b0;
              r_state                <= ST_REFILL;
            end
          end
        end
        ST_REFILL: begin
          if (!r_l2_read) begin
            r_l2_read <= 1'b1;
            r_l2_addr <= {w_tag, w_idx, r_word, {BYTE_W{1'b0}}};
          end else if (bus.l2_cache_ready) begin
            r_l2_read <= 1'b0;
            r_word    <= r_word + 1'b1;
            if (r_word == LAST_WORD) begin
              r_valid[w_idx][r_vway] <= 1'b1;
              r_dirty[w_idx][r_vway] <= r_op_write;
              r_tag[w_idx][r_vway]   <= w_tag;
              // The final word is still on the bus, not yet in the array.
              if (!r_op_write)
                r_cpu_data_out <= (w_woff == r_word) ? bus.l2_cache_data_in
                                                     : r_data[w_idx][r_vway][w_woff];
              r_cpu_ready <= 1'b1;
              r_cpu_hit   <= 1'b0;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_cpu_ready <= 1'b0;
          r_cpu_hit   <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef L1_PERF_CNT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == ST_DONE) begin
      if (r_cpu_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      else           r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`endif

  assign bus.cpu_ready         = r_cpu_ready;
  assign bus.cpu_hit           = r_cpu_hit;
  assign bus.cpu_data_out      = r_cpu_data_out;
  assign bus.l2_cache_addr     = r_l2_addr;
  assign bus.l2_cache_data_out = r_l2_wdata;
  assign bus.l2_cache_read     = r_l2_read;
  assign bus.l2_cache_write    = r_l2_write;

  assign w_unused = ^{r_addr[BYTE_W-1:0], bus.l2_cache_hit};

endmodule

`default_nettype wire

// File: tb/tb_l1_cache_ctrl.sv
// +------------------------------------------------------------------------+
// | tb_l1_cache_ctrl : directed bench for l1_cache_ctrl with an L2 model    |
// | Revision 1.0                                                            |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_l1_cache_ctrl;
  import l1_cache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l1_cache_ctrl_if bus ();

`ifdef L1_PERF_CNT_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  l1_cache_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef L1_PERF_CNT_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // L2 model: word memory, ready pulses after the strobe has been up two cycles
  logic [31:0] mem [0:1023];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  bit          log_wr   [$];
  int          lat      = 0;
  int          both_cnt = 0;

  initial begin
    bus.l2_cache_ready   = 1'b0;
    bus.l2_cache_data_in = '0;
    bus.l2_cache_hit     = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.l2_cache_read && bus.l2_cache_write) both_cnt++;
      if (rst) begin
        bus.l2_cache_ready = 1'b0;
        lat = 0;
      end else if (bus.l2_cache_ready) begin
        bus.l2_cache_ready = 1'b0;
      end else if (bus.l2_cache_read || bus.l2_cache_write) begin
        lat++;
        if (lat == 2) begin
          lat = 0;
          bus.l2_cache_ready = 1'b1;
          bus.l2_cache_hit   = 1'b1;
          log_addr.push_back(bus.l2_cache_addr);
          log_wr.push_back(bus.l2_cache_write);
          if (bus.l2_cache_write) begin
            mem[bus.l2_cache_addr[11:2]] = bus.l2_cache_data_out;
            log_data.push_back(bus.l2_cache_data_out);
          end else begin
            bus.l2_cache_data_in = mem[bus.l2_cache_addr[11:2]];
            log_data.push_back(bus.l2_cache_data_in);
          end
        end
      end else begin
        lat = 0;
      end
    end
  end

  task automatic cpu_req(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic hit,
                         output logic [31:0] rdata, output int cycles, output int l2_ops);
    int start_len;
    @(posedge clk);
    #1;
    start_len       = log_addr.size();
    bus.cpu_addr    = addr;
    bus.cpu_data_in = wdata;
    bus.cpu_read    = rd;
    bus.cpu_write   = wr;
    cycles = 0;
    while (!bus.cpu_ready && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check_value("req_ready", {31'b0, bus.cpu_ready}, 32'd1);
    hit           = bus.cpu_hit;
    rdata         = bus.cpu_data_out;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
    l2_ops        = log_addr.size() - start_len;
  endtask

  logic        hit;
  logic [31:0] rdata;
  int          cyc;
  int          ops;
  int          base;
  logic [31:0] set4_addr [3];
  logic [31:0] wb_data   [4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA5A5_0000 | (i << 2);
    set4_addr[0] = 32'h140; set4_addr[1] = 32'h240; set4_addr[2] = 32'h340;
    wb_data[0] = 32'hDEAD_BEEF; wb_data[1] = 32'hA5A5_0044;
    wb_data[2] = 32'hA5A5_0048; wb_data[3] = 32'hA5A5_004C;
    bus.cpu_addr = '0; bus.cpu_data_in = '0; bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_value("rst_cpu_ready", {31'b0, bus.cpu_ready}, 32'd0);
    check_value("rst_cpu_hit", {31'b0, bus.cpu_hit}, 32'd0);
    check_value("rst_l2_read", {31'b0, bus.l2_cache_read}, 32'd0);
    check_value("rst_l2_write", {31'b0, bus.l2_cache_write}, 32'd0);
    check_value("rst_l2_addr", bus.l2_cache_addr, 32'd0);
    check_value("rst_cpu_data", bus.cpu_data_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Cold read miss
    base = log_addr.size();
    cpu_req(1, 0, 32'h40, 32'h0, hit, rdata, cyc, ops);
    check_value("cold_hit", {31'b0, hit}, 32'd0);
    check_value("cold_data", rdata, 32'hA5A5_0040);
    check_value("cold_l2_ops", ops, WORDS);
    for (int i = 0; i < 4; i++) begin
      check_value("cold_l2_is_read", {31'b0, log_wr[base+i]}, 32'd0);
      check_value("cold_l2_addr", log_addr[base+i], 32'h40 + 32'(4*i));
    end

    // Read hit in the same block
    cpu_req(1, 0, 32'h44, 32'h0, hit, rdata, cyc, ops);
    check_value("hit44_hit", {31'b0, hit}, 32'd1);
    check_value("hit44_latency", cyc, 32'd2);
    check_value("hit44_data", rdata, 32'hA5A5_0044);
    check_value("hit44_l2_ops", ops, 32'd0);

    // Write hit then read back
    cpu_req(0, 1, 32'h40, 32'hDEAD_BEEF, hit, rdata, cyc, ops);
    check_value("wr40_hit", {31'b0, hit}, 32'd1);
    check_value("wr40_l2_ops", ops, 32'd0);
    cpu_req(1, 0, 32'h40, 32'h0, hit, rdata, cyc, ops);
    check_value("rd40_hit", {31'b0, hit}, 32'd1);
    check_value("rd40_data", rdata, 32'hDEAD_BEEF);
    check_value("rd40_l2_ops", ops, 32'd0);

    // Fill the rest of set 4
    for (int k = 0; k < 3; k++) begin
      cpu_req(1, 0, set4_addr[k], 32'h0, hit, rdata, cyc, ops);
      check_value("fill_hit", {31'b0, hit}, 32'd0);
      check_value("fill_data", rdata, 32'hA5A5_0000 | set4_addr[k]);
      check_value("fill_l2_ops", ops, 32'd4);
    end

    // Fifth block evicts the dirty 0x040 block
    base = log_addr.size();
    cpu_req(1, 0, 32'h440, 32'h0, hit, rdata, cyc, ops);
    check_value("evict_hit", {31'b0, hit}, 32'd0);
    check_value("evict_data", rdata, 32'hA5A5_0440);
    check_value("evict_l2_ops", ops, 32'd8);
    for (int i = 0; i < 4; i++) begin
      check_value("wb_is_write", {31'b0, log_wr[base+i]}, 32'd1);
      check_value("wb_addr", log_addr[base+i], 32'h40 + 32'(4*i));
      check_value("wb_data", log_data[base+i], wb_data[i]);
      check_value("refill_is_read", {31'b0, log_wr[base+4+i]}, 32'd0);
      check_value("refill_addr", log_addr[base+4+i], 32'h440 + 32'(4*i));
    end

    // Written-back value comes back from L2; clean LRU victim needs no write-back
    cpu_req(1, 0, 32'h40, 32'h0, hit, rdata, cyc, ops);
    check_value("reload40_hit", {31'b0, hit}, 32'd0);
    check_value("reload40_data", rdata, 32'hDEAD_BEEF);
    check_value("reload40_l2_ops", ops, 32'd4);

    // Simultaneous read+write is a write
    cpu_req(1, 1, 32'h80, 32'h1234, hit, rdata, cyc, ops);
    check_value("rw80_hit", {31'b0, hit}, 32'd0);
    check_value("rw80_l2_ops", ops, 32'd4);
    cpu_req(1, 0, 32'h80, 32'h0, hit, rdata, cyc, ops);
    check_value("rd80_hit", {31'b0, hit}, 32'd1);
    check_value("rd80_data", rdata, 32'h1234);

    // Reset while a refill strobe is up
    @(posedge clk);
    #1;
    base = log_addr.size();
    bus.cpu_addr = 32'h500;
    bus.cpu_read = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (log_addr.size() >= base + 1 && bus.l2_cache_read) break;
    end
    check_value("mid_refill_strobe", {31'b0, bus.l2_cache_read}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_value("mid_rst_l2_read", {31'b0, bus.l2_cache_read}, 32'd0);
    check_value("mid_rst_l2_addr", bus.l2_cache_addr, 32'd0);
    check_value("mid_rst_cpu_ready", {31'b0, bus.cpu_ready}, 32'd0);
    bus.cpu_read = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    cpu_req(1, 0, 32'h500, 32'h0, hit, rdata, cyc, ops);
    check_value("rerd500_hit", {31'b0, hit}, 32'd0);
    check_value("rerd500_data", rdata, 32'hA5A5_0500);
    check_value("rerd500_l2_ops", ops, 32'd4);

`ifdef L1_PERF_CNT_EN
    @(posedge clk);
    #1;
    check_value("perf_hits", hit_count, 32'd0);
    check_value("perf_misses", miss_count, 32'd1);
`endif

    check_value("both_strobes", both_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
